// File: rtl/uart_pkg.sv
// Shared UART types and widths.
// Used by the receive core and the baud tick generator.
package uart_pkg;

  localparam int UART_BAUD_W = 16;
  localparam int UART_DW     = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator.
// Emits one tick every baud+1 cycles while enabled.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [UART_BAUD_W-1:0] baud,
  output logic                   tick
);

  logic [UART_BAUD_W-1:0] div_cnt;

  assign tick = en & (div_cnt == baud);

  // Divider: restarts on clear, on wrap and while disabled.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_cnt <= '0;
    end else if (clr | ~en | tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: sync, start detect, mid-bit sampling.
// One-entry buffer with sticky pending/error flags.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVS         = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   uart_en,
  input  logic                   uart_prty_en,
  input  logic [UART_BAUD_W-1:0] uart_baud,
  input  logic                   uart_rx,
  input  logic                   rxbuf_rd,
  input  logic                   rxpnd_clr,
  output logic [UART_DW-1:0]     rx_data,
  output logic                   rx_valid,
  output logic                   rx_pnd,
  output logic                   rx_perr,
  output logic                   rx_ferr,
  output logic                   rx_ovf,
  output logic                   rx_busy
);

  localparam logic [3:0] SC_MID = 4'(OVS / 2 - 1);
  localparam logic [3:0] SC_END = 4'(OVS - 1);
  localparam logic [2:0] BC_END = 3'(UART_DW - 1);

  rx_state_t            state;
  rx_state_t            state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rx_s;
  logic                 rx_d;
  logic                 start_det;
  logic                 tick;
  logic                 mid_pt;
  logic                 samp;
  logic [3:0]           scnt;
  logic [2:0]           bitcnt;
  logic [UART_DW-1:0]   shreg;
  logic                 perr_tmp;
  logic                 stop_samp;
  logic                 pnd_clr;
  logic                 accept;
  logic                 ovf_set;
  logic                 ferr_set;
  logic                 perr_set;

  assign rx_s      = sync_q[SYNC_STAGES-1];
  assign start_det = rx_d & ~rx_s;

  // Synchroniser chain plus one delay flop for edge detect.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q <= '1;
      rx_d   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      rx_d   <= rx_s;
    end
  end

  uart_baud_tick u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (uart_en),
    .clr     ((state == IDLE) & start_det),
    .baud    (uart_baud),
    .tick    (tick)
  );

  assign mid_pt = (state == START) ? (scnt == SC_MID)
                                   : (scnt == SC_END);
  assign samp   = tick & mid_pt & (state != IDLE);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; disable always forces IDLE.
  always_comb begin
    state_d = state;
    if (!uart_en) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start_det) state_d = START;
        START:   if (samp) state_d = rx_s ? IDLE : DATA;
        DATA:    if (samp && bitcnt == BC_END)
                   state_d = uart_prty_en ? PARITY : STOP;
        PARITY:  if (samp) state_d = STOP;
        STOP:    if (samp) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Sample counter, bit counter, shifter and parity check.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scnt     <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      perr_tmp <= 1'b0;
    end else if (!uart_en || state == IDLE) begin
      scnt <= '0;
    end else begin
      if (tick) scnt <= samp ? 4'd0 : scnt + 4'd1;
      if (samp) begin
        case (state)
          START: begin
            bitcnt   <= '0;
            perr_tmp <= 1'b0;
          end
          DATA: begin
            shreg  <= {rx_s, shreg[UART_DW-1:1]};
            bitcnt <= bitcnt + 3'd1;
          end
          PARITY:  perr_tmp <= (^shreg) ^ rx_s;
          default: ;
        endcase
      end
    end
  end

  // Delivery decisions at the stop-bit sample.
  always_comb begin
    stop_samp = (state == STOP) & samp;
    pnd_clr   = rxbuf_rd | rxpnd_clr;
    accept    = stop_samp & (~rx_pnd | pnd_clr);
    ovf_set   = stop_samp & rx_pnd & ~pnd_clr;
    ferr_set  = stop_samp & ~rx_s;
    perr_set  = stop_samp & perr_tmp;
  end

  // Receive buffer and sticky flags; a set beats a clear.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_pnd   <= 1'b0;
      rx_perr  <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_ovf   <= 1'b0;
    end else begin
      rx_valid <= accept;
      if (accept) rx_data <= shreg;
      rx_pnd  <= accept   | (rx_pnd  & ~pnd_clr);
      rx_perr <= perr_set | (rx_perr & ~rxpnd_clr);
      rx_ferr <= ferr_set | (rx_ferr & ~rxpnd_clr);
      rx_ovf  <= ovf_set  | (rx_ovf  & ~rxpnd_clr);
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: frame-level model plus
// directed literal checks.
module tb_uart_rx_core;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        uart_en = 1'b1;
  logic        uart_prty_en = 1'b0;
  logic [15:0] uart_baud = 16'd3;
  logic        uart_rx = 1'b1;
  logic        rxbuf_rd = 1'b0;
  logic        rxpnd_clr = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pnd;
  logic        rx_perr;
  logic        rx_ferr;
  logic        rx_ovf;
  logic        rx_busy;

  uart_rx_core #(.OVS(8), .SYNC_STAGES(2)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .uart_en      (uart_en),
    .uart_prty_en (uart_prty_en),
    .uart_baud    (uart_baud),
    .uart_rx      (uart_rx),
    .rxbuf_rd     (rxbuf_rd),
    .rxpnd_clr    (rxpnd_clr),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_pnd       (rx_pnd),
    .rx_perr      (rx_perr),
    .rx_ferr      (rx_ferr),
    .rx_ovf       (rx_ovf),
    .rx_busy      (rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Frame timing at 32 clk/bit: 3 detect + 16 half bit,
  // then 32 per data/parity/stop bit to the stop sample.
  localparam int LAT_NOPAR = 3 + 16 + 9 * 32;

  typedef struct {
    int         at;
    logic [7:0] d;
    bit         pe;
    bit         fe;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  bit         chk_on = 1'b0;
  int         vcount = 0;
  int         vrise = 0;
  int         t_start = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_pnd = 1'b0;
  bit         m_perr = 1'b0;
  bit         m_ferr = 1'b0;
  bit         m_ovf = 1'b0;

  // Model: a completed frame arrives at a known edge.
  always @(posedge sys_clk) begin : model
    ev_t ev;
    bit  hit;
    bit  clr;
    cyc++;
    if (sys_rst) begin
      m_data = 8'h00;
      m_valid = 0; m_pnd = 0;
      m_perr = 0; m_ferr = 0; m_ovf = 0;
      evq.delete();
    end else begin
      hit = 0;
      clr = rxbuf_rd | rxpnd_clr;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        hit = 1;
      end
      m_valid = 0;
      m_perr = (m_perr & ~rxpnd_clr) | (hit & ev.pe);
      m_ferr = (m_ferr & ~rxpnd_clr) | (hit & ev.fe);
      m_ovf  = (m_ovf & ~rxpnd_clr) | (hit & m_pnd & ~clr);
      if (hit && (!m_pnd || clr)) begin
        m_data = ev.d;
        m_valid = 1;
        m_pnd = 1;
      end else begin
        m_pnd = m_pnd & ~clr;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge sys_clk) begin
    if (chk_on) begin
      n_tests++;
      if ({rx_data, rx_valid, rx_pnd, rx_perr, rx_ferr, rx_ovf} !==
          {m_data, m_valid, m_pnd, m_perr, m_ferr, m_ovf}) begin
        n_fail++;
        $display("FAIL cycle_cmp @%0d got d=%h v%b p%b pe%b fe%b ov%b want d=%h v%b p%b pe%b fe%b ov%b",
                 cyc, rx_data, rx_valid, rx_pnd, rx_perr, rx_ferr,
                 rx_ovf, m_data, m_valid, m_pnd, m_perr, m_ferr, m_ovf);
      end
      if (rx_valid) begin
        vcount++;
        vrise = cyc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse_rd();
    @(posedge sys_clk); #1; rxbuf_rd = 1'b1;
    @(posedge sys_clk); #1; rxbuf_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge sys_clk); #1; rxpnd_clr = 1'b1;
    @(posedge sys_clk); #1; rxpnd_clr = 1'b0;
  endtask

  // Drive one frame at 32 clk/bit; abort_bit >= 0 drops
  // uart_en halfway through that data bit.
  task automatic send_frame(input logic [7:0] d, input bit par,
                            input bit flip, input bit stop,
                            input int abort_bit);
    logic [10:0] bits;
    int          nb;
    bit          pb;
    ev_t         ev;
    pb = (^d) ^ flip;
    bits = par ? {stop, pb, d, 1'b0} : {1'b0, stop, d, 1'b0};
    nb = par ? 11 : 10;
    @(posedge sys_clk);
    #1;
    t_start = cyc;
    if (abort_bit < 0) begin
      ev.at = cyc + LAT_NOPAR + (par ? 32 : 0);
      ev.d  = d;
      ev.pe = par & ((^d) ^ pb);
      ev.fe = ~stop;
      evq.push_back(ev);
    end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 32; c++) begin
        uart_rx = bits[b];
        if (abort_bit >= 0 && b == abort_bit + 1 && c == 16) begin
          chk("busy_pre_abort", 32'(rx_busy), 32'd1);
          uart_en = 1'b0;
          @(posedge sys_clk);
          #1;
          chk("busy_after_abort", 32'(rx_busy), 32'd0);
          uart_rx = 1'b1;
          return;
        end
        @(posedge sys_clk);
        #1;
      end
    end
    uart_rx = 1'b1;
  endtask

  initial begin : stim
    int  v0;
    int  lat;
    bit  busy_seen;
    idle(4);
    chk("reset_outs",
        32'({rx_data, rx_valid, rx_pnd, rx_perr, rx_ferr,
             rx_ovf, rx_busy}), 32'd0);
    sys_rst = 1'b0;
    chk_on = 1'b1;
    idle(10);

    // Basic byte.
    v0 = vcount;
    send_frame(8'hA5, 0, 0, 1, -1);
    idle(4);
    chk("basic_data", 32'(rx_data), 32'h0000_00A5);
    chk("basic_vcount", 32'(vcount - v0), 32'd1);
    lat = vrise + 1 - t_start;
    chk("basic_fall_lat", 32'(lat >= 306 && lat <= 308), 32'd1);
    chk("basic_pnd", 32'(rx_pnd), 32'd1);
    chk("basic_flags", 32'({rx_perr, rx_ferr, rx_ovf}), 32'd0);

    // Parity good then bad.
    pulse_rd();
    uart_prty_en = 1'b1;
    idle(4);
    send_frame(8'h3C, 1, 0, 1, -1);
    idle(4);
    chk("par_ok_perr", 32'(rx_perr), 32'd0);
    chk("par_ok_data", 32'(rx_data), 32'h0000_003C);
    pulse_rd();
    send_frame(8'h3C, 1, 1, 1, -1);
    idle(4);
    chk("par_bad_perr", 32'(rx_perr), 32'd1);
    chk("par_bad_data", 32'(rx_data), 32'h0000_003C);
    pulse_clr();
    uart_prty_en = 1'b0;
    idle(4);

    // Quarter-bit glitch.
    v0 = vcount;
    busy_seen = 0;
    uart_rx = 1'b0;
    repeat (8) begin
      @(posedge sys_clk); #1;
      busy_seen |= rx_busy;
    end
    uart_rx = 1'b1;
    repeat (30) begin
      @(posedge sys_clk); #1;
      busy_seen |= rx_busy;
    end
    chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
    chk("glitch_idle", 32'(rx_busy), 32'd0);
    chk("glitch_no_valid", 32'(vcount - v0), 32'd0);
    chk("glitch_flags",
        32'({rx_pnd, rx_perr, rx_ferr, rx_ovf}), 32'd0);

    // Frame error.
    send_frame(8'h55, 0, 0, 0, -1);
    idle(4);
    chk("ferr_flag", 32'(rx_ferr), 32'd1);
    chk("ferr_data", 32'(rx_data), 32'h0000_0055);
    chk("ferr_pnd", 32'(rx_pnd), 32'd1);
    pulse_clr();
    chk("ferr_cleared",
        32'({rx_pnd, rx_perr, rx_ferr, rx_ovf}), 32'd0);
    idle(4);

    // Overrun.
    send_frame(8'h11, 0, 0, 1, -1);
    send_frame(8'h22, 0, 0, 1, -1);
    idle(4);
    chk("ovf_flag", 32'(rx_ovf), 32'd1);
    chk("ovf_data_kept", 32'(rx_data), 32'h0000_0011);
    pulse_rd();
    v0 = vcount;
    send_frame(8'h33, 0, 0, 1, -1);
    idle(4);
    chk("ovf_after_rd_data", 32'(rx_data), 32'h0000_0033);
    chk("ovf_after_rd_valid", 32'(vcount - v0), 32'd1);

    // Abort at data bit 4, then recover.
    pulse_clr();
    idle(4);
    v0 = vcount;
    send_frame(8'hF0, 0, 0, 1, 4);
    idle(40);
    chk("abort_no_valid", 32'(vcount - v0), 32'd0);
    uart_en = 1'b1;
    idle(10);
    send_frame(8'h81, 0, 0, 1, -1);
    idle(4);
    chk("abort_recover_data", 32'(rx_data), 32'h0000_0081);
    chk("abort_recover_flags",
        32'({rx_pnd, rx_perr, rx_ferr, rx_ovf}), 32'b1000);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receive path that sits beside the uart_top transmit block and feeds its RX pending and interrupt logic.
- Synchronises the asynchronous uart_rx line and detects the start bit, then samples each bit at mid-period using an oversampling tick generator.
- Deframes 8 data bits, LSB first, plus an optional even-parity bit and one stop bit.
- Holds the received byte in a one-entry buffer with sticky pending, parity, frame and overrun flags for the register interface.

Parameters:
- OVS, 8, sample ticks per bit; even, range 4..16.
- SYNC_STAGES, 2, flops in the uart_rx synchroniser, minimum 2.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- uart_en  in  1  block enable; 0 forces IDLE and holds the tick counter at 0.
- uart_prty_en  in  1  1 = a 9th bit (even parity) is expected between the data bits and the stop bit.
- uart_baud  in  16  sys_clk cycles per sample tick, minus 1.
- uart_rx  in  1  asynchronous serial input; idles high.
- rxbuf_rd  in  1  register read of rxbuf; clears rx_pnd.
- rxpnd_clr  in  1  software clear of rx_pnd, rx_perr, rx_ferr and rx_ovf.
- rx_data  out  8  last accepted byte.
- rx_valid  out  1  one-cycle pulse when rx_data is loaded.
- rx_pnd  out  1  sticky "byte available" flag.
- rx_perr  out  1  sticky parity error.
- rx_ferr  out  1  sticky frame error (stop bit sampled 0).
- rx_ovf  out  1  sticky overrun.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: every output is 0; state is IDLE; tick counter, bit counter and shift register are 0; synchroniser flops are 1.
- Synchroniser and edge detect: the line goes through SYNC_STAGES flops to give rx_s, plus one further flop rx_d. A start edge is rx_d=1 and rx_s=0.
- Detect latency: with SYNC_STAGES=2, a falling edge on uart_rx is detected 3 cycles after it arrives.
- Tick generator: a 16-bit div_cnt emits tick when div_cnt == uart_baud, then wraps to 0.
  - div_cnt is cleared on start detect and while uart_en=0.
  - uart_baud=0 gives a tick every cycle.
- A 4-bit sample counter (scnt) counts ticks within a bit.
- State IDLE:
  - start detect with uart_en=1 -> START; scnt=0.
- State START:
  - at scnt == OVS/2-1 on a tick, sample rx_s.
  - rx_s=1 means a glitch: return to IDLE with no flags set.
  - rx_s=0 -> DATA; scnt=0, bitcnt=0.
- State DATA:
  - on the tick where scnt == OVS-1, shift rx_s into the MSB of a right-shifting register, so bits arrive LSB first.
  - after bitcnt reaches 7 -> PARITY if uart_prty_en=1, else STOP.
- State PARITY:
  - sample at the same point as a data bit.
  - perr_tmp = XOR of the 8 data bits XOR the sampled bit; 1 means mismatch.
  - then -> STOP.
- State STOP: sample at the mid-bit point, then return to IDLE in the same cycle. The line is not waited on, so back-to-back frames are supported.
  - Stop bit = 0: set rx_ferr. The byte is still delivered.
  - Parity: rx_perr |= perr_tmp.
  - rx_pnd=0 (or cleared in this same cycle): load rx_data, pulse rx_valid on the next cycle, set rx_pnd.
  - rx_pnd=1 and not being cleared this cycle: set rx_ovf, leave rx_data unchanged, no rx_valid pulse.
- Simultaneous events:
  - set and clear of rx_pnd in the same cycle: set wins.
  - rxpnd_clr together with an error set: the set wins for that flag.
- uart_prty_en and uart_baud are sampled continuously. Software changes them only while rx_busy=0; any mid-frame change is undefined.
- uart_en dropping mid-frame: the next cycle is IDLE with the frame discarded. Flags and rx_data are retained.
- sys_rst mid-frame: full reset on the next edge.

Decomposition:
- Shared package uart_pkg:
  - state enum rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - width constant UART_BAUD_W = 16;
  - data width constant UART_DW = 8.
- One sub-module, uart_baud_tick: div_cnt, clear and tick output. The transmit path reuses it.
- The synchroniser stays inline.

Test Plan:
- Basic byte: OVS=8, uart_baud=3 (32 clk/bit), no parity, send 0xA5 with a stop bit.
  - rx_data=0xA5, a single rx_valid pulse, rx_pnd=1.
  - rx_valid falls 3 + 16 + 9×32 ±1 cycles after the falling edge.
  - rx_perr = rx_ferr = rx_ovf = 0.
- Parity: uart_prty_en=1.
  - send 0x3C with parity bit 0 -> rx_perr=0;
  - then send 0x3C with parity bit 1 -> rx_perr=1 and rx_data=0x3C.
- Glitch: drive uart_rx low for 8 clk (a quarter bit) then high.
  - rx_busy pulses, then IDLE; no rx_valid, no flags.
- Frame error: send 0x55 with the stop bit held 0.
  - rx_ferr=1, rx_data=0x55, rx_pnd=1.
  - rxpnd_clr pulse -> all flags 0.
- Overrun: send 0x11 then 0x22 back-to-back without rxbuf_rd.
  - rx_ovf=1, rx_data stays 0x11.
  - rxbuf_rd, then send 0x33 -> rx_data=0x33 with no new overrun.
- Abort: drop uart_en at DATA bit 4 while sending 0xF0.
  - rx_busy=0 on the next cycle, no rx_valid.
  - re-enable and send 0x81 -> rx_data=0x81 is received correctly.
